// File: rtl/moving_average_scheduler.sv
// moving_average_scheduler: round-robin time-shared moving average over NUM_CH streams; define MA_WARMUP_FLAG_EN to add out_warm
module moving_average_scheduler #(
  parameter int NUM_CH = 4,
  parameter int k = 3,
  parameter int DATA_WIDTH = 16,
  localparam int ACC_WIDTH = DATA_WIDTH + k,
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic                         clr_valid,
  input  logic [CH_W-1:0]              clr_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_W-1:0]              out_ch,
`ifdef MA_WARMUP_FLAG_EN
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_warm
`else
  output logic signed [DATA_WIDTH-1:0] out_data
`endif
);
  localparam int N = 1 << k;
  logic [NUM_CH-1:0][N-1:0][DATA_WIDTH-1:0] ring;
  logic [NUM_CH-1:0][k-1:0] wp;
  logic [NUM_CH-1:0][ACC_WIDTH-1:0] acc;
  logic [CH_W-1:0] rr, g;
  logic [NUM_CH-1:0] eligible;
  logic hit, slot_free, accept, clr_hit;
  logic [DATA_WIDTH-1:0] d, old;
  logic [ACC_WIDTH-1:0] new_acc;
  assign slot_free = !out_valid || out_ready;
  assign clr_hit = clr_valid && ({1'b0, clr_ch} < (CH_W+1)'(NUM_CH));
  // a channel being cleared this cycle may not also be sampled
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) eligible[c] = req_valid[c] && !(clr_valid && clr_ch == CH_W'(c));
  end
  // scan from farthest to nearest so the first eligible channel at or after rr wins
  always_comb begin
    hit = 1'b0;
    g = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (eligible[(int'(rr) + i) % NUM_CH]) begin
        hit = 1'b1;
        g = CH_W'((int'(rr) + i) % NUM_CH);
      end
  end
  assign accept = hit && slot_free;
  assign req_ready = accept ? NUM_CH'(1) << g : '0;
  assign d = req_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
  assign old = ring[g][wp[g]];
  assign new_acc = acc[g] - {{k{old[DATA_WIDTH-1]}}, old} + {{k{d[DATA_WIDTH-1]}}, d};
  // per-channel context update, output register and round-robin pointer
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ring <= '0;
      wp <= '0;
      acc <= '0;
      rr <= '0;
      out_valid <= 1'b0;
      out_ch <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        ring[g][wp[g]] <= d;
        wp[g] <= wp[g] + 1'b1;
        acc[g] <= new_acc;
        rr <= (g == CH_W'(NUM_CH - 1)) ? '0 : g + 1'b1;
        out_data <= new_acc[ACC_WIDTH-1:k];
        out_ch <= g;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
      if (clr_hit) begin
        ring[clr_ch] <= '0;
        wp[clr_ch] <= '0;
        acc[clr_ch] <= '0;
      end
    end
`ifdef MA_WARMUP_FLAG_EN
  logic [NUM_CH-1:0][k:0] fill;
  logic [k:0] fill_nx;
  assign fill_nx = (fill[g] == (k+1)'(N)) ? fill[g] : fill[g] + 1'b1;
  // saturating per-channel sample count; warm once a full window is present
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fill <= '0;
      out_warm <= 1'b0;
    end else begin
      if (accept) begin
        fill[g] <= fill_nx;
        out_warm <= fill_nx == (k+1)'(N);
      end
      if (clr_hit) fill[clr_ch] <= '0;
    end
`endif
endmodule

// File: tb/tb_moving_average_scheduler.sv
// tb_moving_average_scheduler: directed checks of fill, sign, round-robin, backpressure, clear and async reset
module tb_moving_average_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] req_valid, req_ready;
  logic [63:0] req_data;
  logic clr_valid, out_valid, out_ready;
  logic [1:0] clr_ch, out_ch;
  logic signed [15:0] out_data;
  int tests = 0;
  int fails = 0;
  int n;
`ifdef MA_WARMUP_FLAG_EN
  logic out_warm;
`endif
  always #5 clk = ~clk;
  moving_average_scheduler dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .clr_valid(clr_valid), .clr_ch(clr_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
`ifdef MA_WARMUP_FLAG_EN
    .out_data(out_data), .out_warm(out_warm)
`else
    .out_data(out_data)
`endif
  );
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    req_valid = '0;
    req_data = '0;
    clr_valid = 1'b0;
    clr_ch = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_data", out_data, 0);
    @(negedge clk) reset_n = 1'b1;
    req_valid = 4'b0001;
    req_data[0 +: 16] = 16'sd16;
    for (int i = 0; i < 8; i++) begin
      #1 chk("fill_ready", req_ready, 1);
      tick;
      chk("fill_valid", out_valid, 1);
      chk("fill_ch", out_ch, 0);
      chk("fill_data", out_data, 2 * (i + 1));
`ifdef MA_WARMUP_FLAG_EN
      chk("fill_warm", out_warm, (i == 7) ? 1 : 0);
`endif
    end
    req_valid = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    @(negedge clk) reset_n = 1'b1;
    req_valid = 4'b0001;
    tick;
    chk("arst_after_data", out_data, 2);
    chk("arst_after_ch", out_ch, 0);
    req_valid = 4'b0010;
    req_data[16 +: 16] = -16'sd8;
    for (int i = 0; i < 8; i++) begin
      #1 chk("neg_ready", req_ready, 2);
      tick;
      chk("neg_ch", out_ch, 1);
      chk("neg_data", out_data, -(i + 1));
    end
    req_data[16 +: 16] = 16'sd0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("zero_ch", out_ch, 1);
      chk("zero_data", out_data, i - 7);
    end
    req_valid = '0;
    tick;
    chk("idle_valid", out_valid, 0);
    clr_valid = 1'b1;
    clr_ch = 2'd0;
    tick;
    clr_valid = 1'b0;
    req_valid = 4'b0001;
    tick;
    chk("clr0_data", out_data, 2);
    req_valid = '0;
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 4; c++) req_data[c*16 +: 16] = 16'sd8;
    req_valid = 4'hF;
    n = 0;
    for (int cyc = 0; cyc < 35; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      #1 chk("rr_ready", req_ready, out_ready ? (1 << (n % 4)) : 0);
      tick;
      chk("rr_valid", out_valid, 1);
      if (!out_ready) begin
        chk("bp_ch", out_ch, (n - 1) % 4);
        chk("bp_data", out_data, (n - 1) / 4 + 1);
      end else begin
        chk("rr_ch", out_ch, n % 4);
        chk("rr_data", out_data, n / 4 + 1);
`ifdef MA_WARMUP_FLAG_EN
        chk("rr_warm", out_warm, (n / 4 == 7) ? 1 : 0);
`endif
        n++;
      end
    end
    out_ready = 1'b1;
    req_valid = 4'b1100;
    clr_valid = 1'b1;
    clr_ch = 2'd2;
    #1 chk("clr_ready", req_ready, 8);
    tick;
    chk("clr_other_ch", out_ch, 3);
    chk("clr_other_data", out_data, 8);
    clr_valid = 1'b0;
    req_valid = 4'b0100;
    #1 chk("clr2_ready", req_ready, 4);
    tick;
    chk("clr2_ch", out_ch, 2);
    chk("clr2_data", out_data, 1);
`ifdef MA_WARMUP_FLAG_EN
    chk("clr2_warm", out_warm, 0);
`endif
    req_valid = '0;
    tick;
    chk("end_valid", out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
